// File: rtl/mem_write_checker_pkg.sv
// Shared types for the data-memory write checker.
//   u1 / u32      : scalar and 32-bit word shorthands
//   chk_state_t   : checker FSM states
//   chk_fail_t    : 3-bit failure codes reported on fail_code
//   sat_inc32     : saturating 32-bit increment used by the cycle counter
package mem_write_checker_pkg;

    typedef logic        u1;
    typedef logic [31:0] u32;

    typedef enum logic [1:0] {
        ST_CHECK = 2'd0,
        ST_PASS  = 2'd1,
        ST_FAIL  = 2'd2
    } chk_state_t;

    typedef enum logic [2:0] {
        FAIL_NONE    = 3'd0,
        FAIL_ADDR    = 3'd1,
        FAIL_DATA    = 3'd2,
        FAIL_ORDER   = 3'd3,
        FAIL_DUP     = 3'd4,
        FAIL_TIMEOUT = 3'd5
    } chk_fail_t;

    // Holds at all-ones instead of wrapping.
    function automatic u32 sat_inc32(input u32 v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/mem_write_checker_exp_match.sv
// Combinational NUM_EXP-way comparator of one store against the expected table.
//   dataaddr, writedata   : store under test
//   exp_addr, exp_data    : expected table, entry 0 first
//   seen                  : entries excluded from selection (already matched / not eligible)
//   any_addr_hit          : address equals some table entry, seen or not
//   first_unseen_idx      : lowest non-excluded entry whose address matches
//   first_unseen_valid    : first_unseen_idx is meaningful
//   data_ok               : writedata equals exp_data of the selected entry
module exp_match
    import mem_write_checker_pkg::*;
#(
    parameter int unsigned NUM_EXP = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [ADDR_W-1:0]               dataaddr,
    input  logic [DATA_W-1:0]               writedata,
    input  logic [NUM_EXP-1:0][ADDR_W-1:0]  exp_addr,
    input  logic [NUM_EXP-1:0][DATA_W-1:0]  exp_data,
    input  logic [NUM_EXP-1:0]              seen,
    output logic                            any_addr_hit,
    output logic [IDX_W-1:0]                first_unseen_idx,
    output logic                            first_unseen_valid,
    output logic                            data_ok
);

    logic [DATA_W-1:0] sel_data;

    // Scan from the top so the lowest matching unseen entry wins.
    always_comb begin
        any_addr_hit       = 1'b0;
        first_unseen_idx   = '0;
        first_unseen_valid = 1'b0;
        sel_data           = '0;
        for (int j = NUM_EXP - 1; j >= 0; j--) begin
            if (exp_addr[j] == dataaddr) begin
                any_addr_hit = 1'b1;
                if (!seen[j]) begin
                    first_unseen_valid = 1'b1;
                    first_unseen_idx   = IDX_W'(j);
                    sel_data           = exp_data[j];
                end
            end
        end
        data_ok = first_unseen_valid && (sel_data == writedata);
    end

endmodule

// File: rtl/mem_write_checker.sv
// Scoreboard on the CPU data-memory write port: checks stores against a table
// of expected (address, data) pairs, in order or in any order, with optional timeout.
//   clk, reset            : clock, asynchronous active-high reset
//   memwrite, dataaddr,
//   writedata             : observed store
//   exp_addr, exp_data    : expected table (static while out of reset)
//   hit                   : one-cycle pulse after a matching store
//   done / fail           : sticky outcome
//   fail_code, fail_addr,
//   fail_data             : record of the failing store (zeros for timeout)
//   hit_count             : entries matched so far
//   cycle_count           : edges spent in CHECK, saturating
module mem_write_checker
    import mem_write_checker_pkg::*;
#(
    parameter int unsigned NUM_EXP = 3,
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter bit          ORDERED = 1'b1,
    parameter int unsigned TIMEOUT = 0
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 memwrite,
    input  logic [ADDR_W-1:0]                    dataaddr,
    input  logic [DATA_W-1:0]                    writedata,
    input  logic [NUM_EXP-1:0][ADDR_W-1:0]       exp_addr,
    input  logic [NUM_EXP-1:0][DATA_W-1:0]       exp_data,
    output logic                                 hit,
    output logic                                 done,
    output logic                                 fail,
    output logic [2:0]                           fail_code,
    output logic [ADDR_W-1:0]                    fail_addr,
    output logic [DATA_W-1:0]                    fail_data,
    output logic [$clog2(NUM_EXP+1)-1:0]         hit_count,
    output logic [31:0]                          cycle_count
);

    localparam int unsigned IDX_W    = (NUM_EXP > 1) ? $clog2(NUM_EXP) : 1;
    localparam int unsigned CNT_W    = $clog2(NUM_EXP + 1);
    localparam u32          TO_LIMIT = (TIMEOUT == 0) ? 32'd0 : 32'(TIMEOUT - 1);

    chk_state_t          state;
    logic [NUM_EXP-1:0]  seen;
    logic [NUM_EXP-1:0]  order_mask;
    logic [NUM_EXP-1:0]  match_mask;
    logic [NUM_EXP-1:0]  seen_next;
    logic                any_addr_hit;
    logic [IDX_W-1:0]    first_unseen_idx;
    logic                first_unseen_valid;
    logic                data_ok;
    u32                  cnt_next;
    logic                timeout_now;

    // In ordered mode hit_count is the table index; every other entry is masked off.
    always_comb begin
        order_mask  = ORDERED ? ~(NUM_EXP'(1) << hit_count) : '0;
        match_mask  = seen | order_mask;
        seen_next   = seen | (NUM_EXP'(1) << first_unseen_idx);
        cnt_next    = sat_inc32(cycle_count);
        timeout_now = (TIMEOUT != 0) && (cnt_next >= TO_LIMIT);
    end

    exp_match #(
        .NUM_EXP (NUM_EXP),
        .ADDR_W  (ADDR_W),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) u_match (
        .dataaddr           (dataaddr),
        .writedata          (writedata),
        .exp_addr           (exp_addr),
        .exp_data           (exp_data),
        .seen               (match_mask),
        .any_addr_hit       (any_addr_hit),
        .first_unseen_idx   (first_unseen_idx),
        .first_unseen_valid (first_unseen_valid),
        .data_ok            (data_ok)
    );

    // Checker FSM, counters and failure capture; store result outranks timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_CHECK;
            seen        <= '0;
            hit         <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            fail_code   <= 3'(FAIL_NONE);
            fail_addr   <= '0;
            fail_data   <= '0;
            hit_count   <= '0;
            cycle_count <= '0;
        end else begin
            hit <= 1'b0;
            if (state == ST_CHECK) begin
                cycle_count <= cnt_next;
                if (memwrite) begin
                    if (data_ok) begin
                        hit       <= 1'b1;
                        seen      <= seen_next;
                        hit_count <= hit_count + CNT_W'(1);
                        if (&seen_next) begin
                            state <= ST_PASS;
                            done  <= 1'b1;
                        end
                    end else begin
                        state     <= ST_FAIL;
                        fail      <= 1'b1;
                        fail_addr <= dataaddr;
                        fail_data <= writedata;
                        if (first_unseen_valid)
                            fail_code <= 3'(FAIL_DATA);
                        else if (any_addr_hit)
                            fail_code <= ORDERED ? 3'(FAIL_ORDER) : 3'(FAIL_DUP);
                        else
                            fail_code <= 3'(FAIL_ADDR);
                    end
                end else if (timeout_now) begin
                    state     <= ST_FAIL;
                    fail      <= 1'b1;
                    fail_code <= 3'(FAIL_TIMEOUT);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_write_checker.sv
// Self-checking bench for mem_write_checker: three instances (ordered, unordered,
// ordered with TIMEOUT=20) share the stimulus; a scoreboard queue of expected
// per-cycle outputs is compared against the instance under test.
module tb_mem_write_checker;

    typedef struct {
        logic       hit;
        logic       done;
        logic       fail;
        logic [2:0] code;
        logic [1:0] hcnt;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  memwrite;
    logic [31:0]           dataaddr;
    logic [31:0]           writedata;
    logic [2:0][31:0]      exp_addr;
    logic [2:0][31:0]      exp_data;

    logic [2:0]            hit_v;
    logic [2:0]            done_v;
    logic [2:0]            fail_v;
    logic [2:0][2:0]       code_v;
    logic [2:0][31:0]      faddr_v;
    logic [2:0][31:0]      fdata_v;
    logic [2:0][1:0]       hcnt_v;
    logic [2:0][31:0]      cyc_v;

    int   sel;
    int   n_checks = 0;
    int   n_fail   = 0;
    exp_t sb[$];

    always #5 clk = ~clk;

    mem_write_checker #(.ORDERED(1'b1), .TIMEOUT(0)) u_ord (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data),
        .hit(hit_v[0]), .done(done_v[0]), .fail(fail_v[0]), .fail_code(code_v[0]),
        .fail_addr(faddr_v[0]), .fail_data(fdata_v[0]), .hit_count(hcnt_v[0]),
        .cycle_count(cyc_v[0])
    );

    mem_write_checker #(.ORDERED(1'b0), .TIMEOUT(0)) u_unord (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data),
        .hit(hit_v[1]), .done(done_v[1]), .fail(fail_v[1]), .fail_code(code_v[1]),
        .fail_addr(faddr_v[1]), .fail_data(fdata_v[1]), .hit_count(hcnt_v[1]),
        .cycle_count(cyc_v[1])
    );

    mem_write_checker #(.ORDERED(1'b1), .TIMEOUT(20)) u_to (
        .clk(clk), .reset(reset), .memwrite(memwrite), .dataaddr(dataaddr),
        .writedata(writedata), .exp_addr(exp_addr), .exp_data(exp_data),
        .hit(hit_v[2]), .done(done_v[2]), .fail(fail_v[2]), .fail_code(code_v[2]),
        .fail_addr(faddr_v[2]), .fail_data(fdata_v[2]), .hit_count(hcnt_v[2]),
        .cycle_count(cyc_v[2])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s (inst %0d): got %0d, expected %0d", tag, sel, got, want);
        end
    endtask

    function automatic exp_t mk(input logic h, input logic d, input logic f,
                                input logic [2:0] c, input logic [1:0] n);
        exp_t e;
        e.hit = h; e.done = d; e.fail = f; e.code = c; e.hcnt = n;
        return e;
    endfunction

    // Pop one expectation and compare it with the selected instance.
    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("scoreboard_underflow", 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk("hit",       32'(hit_v[sel]),  32'(e.hit));
            chk("done",      32'(done_v[sel]), 32'(e.done));
            chk("fail",      32'(fail_v[sel]), 32'(e.fail));
            chk("fail_code", 32'(code_v[sel]), 32'(e.code));
            chk("hit_count", 32'(hcnt_v[sel]), 32'(e.hcnt));
        end
    endtask

    // Starts and ends on a falling edge; one rising edge in between.
    task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input exp_t e);
        memwrite  = mw;
        dataaddr  = a;
        writedata = d;
        sb.push_back(e);
        @(posedge clk);
        #1;
        compare();
        memwrite = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset    = 1'b1;
        memwrite = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic idle(input int n, input exp_t e);
        for (int k = 0; k < n; k++) step(1'b0, 32'd0, 32'd0, e);
    endtask

    initial begin
        reset       = 1'b1;
        memwrite    = 1'b0;
        dataaddr    = '0;
        writedata   = '0;
        exp_addr[0] = 32'd80; exp_data[0] = 32'd7;
        exp_addr[1] = 32'd84; exp_data[1] = 32'd7;
        exp_addr[2] = 32'd88; exp_data[2] = 32'd9;
        sel = 0;

        // Reset state
        do_reset();
        #1;
        sb.push_back(mk(0, 0, 0, 0, 0));
        compare();
        chk("reset_cycle_count", cyc_v[0], 32'd0);
        chk("reset_fail_addr",   faddr_v[0], 32'd0);
        @(negedge clk);

        // Ordered in-order pass
        sel = 0;
        do_reset();
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd84, 32'd7, mk(1, 0, 0, 0, 2));
        step(1, 32'd88, 32'd9, mk(1, 1, 0, 0, 3));
        idle(2, mk(0, 1, 0, 0, 3));
        chk("pass_cycle_frozen", cyc_v[0], 32'd3);

        // Ordered data mismatch, later stores ignored
        do_reset();
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd84, 32'd5, mk(0, 0, 1, 2, 1));
        chk("data_fail_addr", faddr_v[0], 32'd84);
        chk("data_fail_data", fdata_v[0], 32'd5);
        step(1, 32'd88, 32'd9, mk(0, 0, 1, 2, 1));
        chk("data_fail_addr_held", faddr_v[0], 32'd84);

        // Ordered: out-of-order store is an ORDER failure
        do_reset();
        step(1, 32'd88, 32'd9, mk(0, 0, 1, 3, 0));

        // Ordered: unknown address
        do_reset();
        step(1, 32'd100, 32'd1, mk(0, 0, 1, 1, 0));
        chk("ord_addr_fail_addr", faddr_v[0], 32'd100);

        // Unordered: any order passes
        sel = 1;
        do_reset();
        step(1, 32'd88, 32'd9, mk(1, 0, 0, 0, 1));
        step(1, 32'd84, 32'd7, mk(1, 0, 0, 0, 2));
        step(1, 32'd80, 32'd7, mk(1, 1, 0, 0, 3));

        // Unordered: duplicate store
        do_reset();
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd80, 32'd7, mk(0, 0, 1, 4, 1));

        // Unordered: unknown address after a hit
        do_reset();
        step(1, 32'd84, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd100, 32'd7, mk(0, 0, 1, 1, 1));
        chk("unord_addr_fail_addr", faddr_v[1], 32'd100);

        // Unordered: right address, wrong data
        do_reset();
        step(1, 32'd88, 32'd8, mk(0, 0, 1, 2, 0));

        // Timeout with no stores
        sel = 2;
        do_reset();
        idle(18, mk(0, 0, 0, 0, 0));
        chk("to_cycle_before", cyc_v[2], 32'd18);
        idle(1, mk(0, 0, 1, 5, 0));
        chk("to_cycle_at_fail", cyc_v[2], 32'd19);
        chk("to_fail_addr",     faddr_v[2], 32'd0);
        chk("to_fail_data",     fdata_v[2], 32'd0);
        idle(3, mk(0, 0, 1, 5, 0));
        chk("to_cycle_frozen", cyc_v[2], 32'd19);

        // Final matching store on the timeout edge wins
        do_reset();
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd84, 32'd7, mk(1, 0, 0, 0, 2));
        idle(16, mk(0, 0, 0, 0, 2));
        step(1, 32'd88, 32'd9, mk(1, 1, 0, 0, 3));
        chk("to_pass_cycle", cyc_v[2], 32'd19);

        // Asynchronous reset mid-sequence, then replay
        sel = 0;
        do_reset();
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        #2;
        reset = 1'b1;
        #1;
        chk("async_hit",       32'(hit_v[0]),  32'd0);
        chk("async_hit_count", 32'(hcnt_v[0]), 32'd0);
        chk("async_cycle",     cyc_v[0],       32'd0);
        chk("async_fail",      32'(fail_v[0]), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        step(1, 32'd80, 32'd7, mk(1, 0, 0, 0, 1));
        step(1, 32'd84, 32'd7, mk(1, 0, 0, 0, 2));
        step(1, 32'd88, 32'd9, mk(1, 1, 0, 0, 3));

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
